ifetch_unit: RTL and testbench

Instruction-fetch front end: the initiator side of the instruction-ROM read interface. It holds the PC, drives the word address to the combinational instruction ROM, and captures the returned word into an IF/ID pipeline register. It handles stall, branch redirect (PC-relative 16-bit word offset, beq-style) and absolute jump redirect with flush. It sits between the ROM and the decode stage of the MIPS-subset core.

---
 rtl/ifetch_unit.sv | 98 +++++++++
 tb/tb_ifetch_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// ============================================================================
// ifetch_unit : instruction-fetch front end (PC, ROM address, IF/ID register)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_offset,
   input  logic        jump_req,
   input  logic [31:0] jump_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc4,
   output logic        if_valid,
   output logic        misalign_err
);

   generate
      if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
         $error("ifetch_unit: RESET_PC %h is not word-aligned", RESET_PC);
      end
   endgenerate

   logic [31:0] pc_q, pc_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_pc4_q, if_pc4_d;
   logic        if_valid_q, if_valid_d;
   logic        misalign_q, misalign_d;
   logic [31:0] branch_target;
   logic [31:0] pc_plus4;

   assign pc_plus4      = pc_q + 32'd4;
   assign branch_target = if_pc4_q + {{14{branch_offset[15]}}, branch_offset, 2'b00};

   // Redirects outrank stall; a branch only counts against a real instruction.
   always_comb begin
      pc_d       = pc_q;
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;
      if_pc4_d   = if_pc4_q;
      if_valid_d = if_valid_q;
      misalign_d = 1'b0;
      if (jump_req) begin
         pc_d       = {jump_target[31:2], 2'b00};
         if_instr_d = NOP_WORD;
         if_valid_d = 1'b0;
         misalign_d = |jump_target[1:0];
      end else if (branch_taken && if_valid_q) begin
         pc_d       = {branch_target[31:2], 2'b00};
         if_instr_d = NOP_WORD;
         if_valid_d = 1'b0;
      end else if (!stall) begin
         pc_d       = pc_plus4;
         if_instr_d = imem_data;
         if_pc_d    = pc_q;
         if_pc4_d   = pc_plus4;
         if_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= {RESET_PC[31:2], 2'b00};
         if_instr_q <= NOP_WORD;
         if_pc_q    <= 32'd0;
         if_pc4_q   <= 32'd0;
         if_valid_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         if_instr_q <= if_instr_d;
         if_pc_q    <= if_pc_d;
         if_pc4_q   <= if_pc4_d;
         if_valid_q <= if_valid_d;
         misalign_q <= misalign_d;
      end
   end

   assign imem_addr    = pc_q;
   assign if_instr     = if_instr_q;
   assign if_pc        = if_pc_q;
   assign if_pc4       = if_pc4_q;
   assign if_valid     = if_valid_q;
   assign misalign_err = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// ============================================================================
// tb_ifetch_unit : directed self-checking bench for ifetch_unit
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_offset;
   logic        jump_req;
   logic [31:0] jump_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc4;
   logic        if_valid;
   logic        misalign_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // ROM word at byte address A is 0x1000_0000 + A.
   assign imem_data = 32'h1000_0000 + imem_addr;

   ifetch_unit #(
      .RESET_PC (32'h0000_0000),
      .NOP_WORD (32'h0000_0000)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump_req      (jump_req),
      .jump_target   (jump_target),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .if_instr      (if_instr),
      .if_pc         (if_pc),
      .if_pc4        (if_pc4),
      .if_valid      (if_valid),
      .misalign_err  (misalign_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_offset = 16'h0000;
      jump_req      = 1'b0;
      jump_target   = 32'h0;
   endtask

   task automatic check_ifid(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                             input logic [31:0] pc, input logic [31:0] pc4, input logic valid);
      check_eq({tag, ".addr"},  imem_addr, addr);
      check_eq({tag, ".instr"}, if_instr, instr);
      check_eq({tag, ".pc"},    if_pc, pc);
      check_eq({tag, ".pc4"},   if_pc4, pc4);
      check_eq({tag, ".valid"}, {31'd0, if_valid}, {31'd0, valid});
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      @(negedge clk);
      step();
      check_ifid("reset", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      check_eq("reset.mis", {31'd0, misalign_err}, 32'd0);
      reset = 1'b0;

      // Free-running fetch from 0
      for (int k = 1; k <= 4; k++) begin
         step();
         check_ifid($sformatf("run%0d", k), 32'(4 * k), 32'h1000_0000 + 32'(4 * (k - 1)),
                    32'(4 * (k - 1)), 32'(4 * k), 1'b1);
      end
      // Advance until if_pc = 0x24
      for (int k = 0; k < 6; k++) step();
      check_ifid("pre_br", 32'h28, 32'h1000_0024, 32'h24, 32'h28, 1'b1);

      // Backward branch: 0x28 + (-6 << 2) = 0x10
      branch_taken  = 1'b1;
      branch_offset = 16'hFFFA;
      step();
      check_ifid("branch", 32'h10, 32'h0, 32'h24, 32'h28, 1'b0);
      // Branch against a bubble is ignored
      branch_offset = 16'h0100;
      step();
      check_ifid("br_bubble", 32'h14, 32'h1000_0010, 32'h10, 32'h14, 1'b1);
      idle_inputs();

      // Stall at pc=0x8
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      step();
      check_ifid("pre_stall", 32'h8, 32'h1000_0004, 32'h4, 32'h8, 1'b1);
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check_ifid($sformatf("stall%0d", k), 32'h8, 32'h1000_0004, 32'h4, 32'h8, 1'b1);
      end
      stall = 1'b0;
      step();
      check_ifid("resume0", 32'hC, 32'h1000_0008, 32'h8, 32'hC, 1'b1);
      step();
      check_ifid("resume1", 32'h10, 32'h1000_000C, 32'hC, 32'h10, 1'b1);

      // Misaligned jump beats branch and stall
      jump_req      = 1'b1;
      jump_target   = 32'h0000_0042;
      stall         = 1'b1;
      branch_taken  = 1'b1;
      branch_offset = 16'h0004;
      step();
      check_ifid("jump", 32'h40, 32'h0, 32'hC, 32'h10, 1'b0);
      check_eq("jump.mis", {31'd0, misalign_err}, 32'd1);
      idle_inputs();
      stall = 1'b1;
      step();
      check_eq("jump.mis_clr", {31'd0, misalign_err}, 32'd0);
      check_ifid("jump_stall", 32'h40, 32'h0, 32'hC, 32'h10, 1'b0);
      stall = 1'b0;
      step();
      check_ifid("post_jump", 32'h44, 32'h1000_0040, 32'h40, 32'h44, 1'b1);

      // Wraparound at top of address space
      jump_req    = 1'b1;
      jump_target = 32'hFFFF_FFFC;
      step();
      check_eq("wrap.addr", imem_addr, 32'hFFFF_FFFC);
      check_eq("wrap.mis", {31'd0, misalign_err}, 32'd0);
      idle_inputs();
      step();
      check_ifid("wrap0", 32'h0, 32'h0FFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b1);
      step();
      check_ifid("wrap1", 32'h4, 32'h1000_0000, 32'h0, 32'h4, 1'b1);

      // Reset wins over a simultaneous jump/stall/branch
      reset        = 1'b1;
      jump_req     = 1'b1;
      jump_target  = 32'h0000_0083;
      stall        = 1'b1;
      branch_taken = 1'b1;
      step();
      check_ifid("rst_jump", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      check_eq("rst_jump.mis", {31'd0, misalign_err}, 32'd0);
      reset = 1'b0;
      idle_inputs();
      step();
      check_ifid("rst_after", 32'h4, 32'h1000_0000, 32'h0, 32'h4, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
